// File: rtl/clk_div_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_monitor
// Purpose  : Measures period and high time of a divided clock in the source
//            domain, tracks lock to the expected ratio, flags deviations.
// Revision : 1.0  initial release
// ============================================================================
module clk_div_monitor #(
    parameter int EXP_DIV     = 4,
    parameter int CNT_W       = 8,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_vld,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam int               c_MATCH_W  = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_EXP      = CNT_W'(EXP_DIV);
    localparam logic [CNT_W-1:0] c_HALF_LO  = CNT_W'(EXP_DIV / 2);
    localparam logic [CNT_W-1:0] c_HALF_HI  = CNT_W'((EXP_DIV + 1) / 2);
    localparam logic [c_MATCH_W-1:0] c_LOCK    = c_MATCH_W'(LOCK_CNT);
    localparam logic [c_MATCH_W-1:0] c_LOCK_M1 = c_MATCH_W'(LOCK_CNT - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_MEASURE = 2'd1;
    localparam logic [1:0] c_LOCKED  = 2'd2;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_q;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_high_len;
    logic                   r_fall_seen;
    logic [c_MATCH_W-1:0]   r_match_cnt;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       r_high_time;
    logic                   r_period_vld;
    logic                   r_locked;
    logic                   r_err;
    logic [7:0]             r_err_cnt;

    logic                   w_rise;
    logic                   w_fall;
    logic [CNT_W-1:0]       w_high;
    logic                   w_match;
    logic                   w_lock_hit;

    assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_sync_q;
    assign w_fall     = ~r_sync[SYNC_STAGES-1] & r_sync_q;
    // A period with no fall seen reports its full length as high time.
    assign w_high     = r_fall_seen ? r_high_len : r_cnt;
    assign w_match    = (r_cnt == c_EXP) && ((w_high == c_HALF_LO) || (w_high == c_HALF_HI));
    assign w_lock_hit = (r_match_cnt == c_LOCK_M1) || (r_match_cnt == c_LOCK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync      <= '0;
            r_sync_q    <= 1'b0;
            r_cnt       <= '0;
            r_high_len  <= '0;
            r_fall_seen <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], div_in};
            r_sync_q <= r_sync[SYNC_STAGES-1];
            // The rise cycle is the first cycle of the new period.
            if (w_rise) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_rise) begin
                r_fall_seen <= 1'b0;
            end else if (w_fall && (r_state != c_IDLE) && !r_fall_seen) begin
                r_fall_seen <= 1'b1;
                r_high_len  <= r_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_match_cnt  <= '0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_period_vld <= 1'b0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_period_vld <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_rise) begin
                        r_state <= c_MEASURE;
                    end
                end
                c_MEASURE, c_LOCKED: begin
                    if (w_rise) begin
                        r_period     <= r_cnt;
                        r_high_time  <= w_high;
                        r_period_vld <= 1'b1;
                        if (w_match) begin
                            if (r_match_cnt != c_LOCK) begin
                                r_match_cnt <= r_match_cnt + 1'b1;
                            end
                            if (w_lock_hit) begin
                                r_locked <= 1'b1;
                                r_state  <= c_LOCKED;
                            end
                        end else begin
                            r_err       <= 1'b1;
                            r_match_cnt <= '0;
                            r_locked    <= 1'b0;
                            r_state     <= c_MEASURE;
                            if (r_err_cnt != 8'hFF) begin
                                r_err_cnt <= r_err_cnt + 8'd1;
                            end
                        end
                    end else if (r_cnt == c_CNT_MAX) begin
                        // Stuck input: report once, then wait for activity in IDLE.
                        r_err       <= 1'b1;
                        r_match_cnt <= '0;
                        r_locked    <= 1'b0;
                        r_state     <= c_IDLE;
                        if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign period_vld = r_period_vld;
    assign locked     = r_locked;
    assign err        = r_err;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
Consumer-side checker for the divide-by-N clock output (po_cnt) of the clock divider. It samples the divided clock in the source clock domain and measures its period and high time in source-clock cycles. It asserts lock after a run of periods matching the expected ratio and flags and counts deviations and stuck clocks. It sits beside the divider in the clock subsystem as a built-in self-check.

Parameters:
EXP_DIV, 4, expected division ratio in clk cycles per divided period (>=2)
CNT_W, 8, width of period/high-time counters and the timeout limit (2^CNT_W-1)
LOCK_CNT, 4, consecutive matching periods required to assert locked (>=1)
SYNC_STAGES, 2, synchronizer flops on div_in (>=2)

Ports:
clk  input  1  source clock; all logic on the rising edge
rst  input  1  asynchronous, active-low reset
div_in  input  1  divided clock under test (driven by po_cnt)
period  output  CNT_W  last measured period, in clk cycles
high_time  output  CNT_W  last measured high time, in clk cycles
period_vld  output  1  one-cycle pulse when period/high_time update
locked  output  1  ratio and duty confirmed
err  output  1  one-cycle pulse on mismatch or timeout
err_cnt  output  8  saturating error count

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM=IDLE, all counters 0, synchronizer flops 0.
- div_in passes through SYNC_STAGES flops, then a rise/fall edge detector. Detection latency is SYNC_STAGES+1 clk cycles after the div_in transition. It is constant, so measurements are unaffected.
- Measurement counter cnt: increments every cycle and saturates at 2^CNT_W-1. Period is the number of clk cycles between consecutive rise detections. High time is the number of cycles from a rise detection to the following fall detection.
- FSM IDLE: waits for the first rise detection, then goes to MEASURE. This first rise produces no measurement.
- FSM MEASURE/LOCKED: every subsequent rise detection, in the same cycle:
  - period, high_time are registered.
  - period_vld pulses on the next cycle, together with updated period/high_time/locked/err.
- Match rule:
  - period == EXP_DIV, and
  - high_time equals EXP_DIV/2 (floor) or (EXP_DIV+1)/2. For odd EXP_DIV both values are accepted.
- On a match: match_cnt increments (saturating at LOCK_CNT). When it reaches LOCK_CNT, locked=1 and the FSM moves to LOCKED. locked rises in the same cycle as the period_vld of the LOCK_CNT-th matching measurement.
- On a mismatch (from MEASURE or LOCKED):
  - err pulses for one cycle.
  - err_cnt increments, saturating at 255.
  - match_cnt=0, locked=0, FSM=MEASURE.
  - The mismatched period is still reported with period_vld.
- If no fall is detected before the next rise, high_time reports the full period, which is a mismatch.
- Timeout: if cnt reaches 2^CNT_W-1 without a rise detection (stuck high or low):
  - err pulses once, err_cnt increments.
  - locked=0, match_cnt=0, FSM=IDLE.
  - period_vld is not asserted.
  - No further err until activity resumes and times out again.
- Simultaneous timeout and rise detection: the rise takes priority and is measured normally. The reported period is saturated, so it mismatches.
- Reset mid-operation: immediate return to reset values. Lock must be re-earned: first rise arms, then LOCK_CNT matches.
- err and period_vld are never asserted in IDLE before the first rise.

Test Plan:
- Default params, div_in = clean divide-by-4 (2 high/2 low, rise every 4 clk) after reset release at 50 ns -> first period_vld shows period=4, high_time=2. period_vld pulses every 4 cycles. locked=1 with the 4th period_vld (5th rising edge). err never pulses; err_cnt=0.
- Locked, then one period stretched to 6 clk (3 high/3 low) -> period=6, high_time=3, err pulse 1 cycle, err_cnt=1, locked=0. Relock after 4 further clean periods.
- Locked, then hold div_in high -> err pulses exactly once after cnt saturates at 255, locked=0, FSM IDLE, err_cnt increments once. Restart a clean div-by-4 -> lock after 1 arming edge + 4 matches.
- Duty error: period 4 with 3 high/1 low -> period=4, high_time=3, mismatch, err pulse, locked stays 0.
- EXP_DIV=3: high_time 1 or 2 with period 3 -> both accepted. Lock asserts; err stays 0.
- Assert rst mid-lock, then inject 300 mismatching periods -> all outputs 0 during reset; err_cnt saturates at 255 and does not wrap.
